// File: rtl/rcpu_irq_pkg.sv
// Shared types and constants for the rcpu interrupt-event queue.
package rcpu_irq_pkg;

  localparam logic SRC_KEY = 1'b0;
  localparam logic SRC_BP  = 1'b1;

  localparam int unsigned KEY_CODE_W  = 9;
  localparam int unsigned IRQ_DATA_W  = 16;
  localparam int unsigned IRQ_VEC_W   = 32;
  localparam int unsigned IRQ_ENTRY_W = 1 + IRQ_DATA_W + IRQ_VEC_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } irq_state_e;

  // One queued event: {src, data, vec}
  typedef struct packed {
    logic                  src;
    logic [IRQ_DATA_W-1:0] data;
    logic [IRQ_VEC_W-1:0]  vec;
  } irq_entry_t;

  // Key events carry the zero-extended scancode as payload
  function automatic irq_entry_t mk_key_entry(input logic [KEY_CODE_W-1:0] code,
                                              input logic [IRQ_VEC_W-1:0]  vec);
    irq_entry_t e;
    e.src  = SRC_KEY;
    e.data = IRQ_DATA_W'(code);
    e.vec  = vec;
    return e;
  endfunction

endpackage

// File: rtl/irq_sync_fifo.sv
// Event FIFO: up to two in-order writes and one read per cycle.
module irq_sync_fifo
  import rcpu_irq_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       push_n_i,
  input  irq_entry_t       push0_i,
  input  irq_entry_t       push1_i,
  input  logic             pop_i,
  output irq_entry_t       head_c,
  output logic             empty_c,
  output logic [PTR_W:0]   used_o,
  output logic [PTR_W:0]   freeSlots
);

  irq_entry_t       mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   used_q, used_d;
  logic [PTR_W-1:0] wr_idx0, wr_idx1;

  // Pointer, occupancy and status arithmetic
  always_comb begin
    wr_idx0   = wr_ptr_q[PTR_W-1:0];
    wr_idx1   = wr_idx0 + PTR_W'(1);
    wr_ptr_d  = wr_ptr_q + (PTR_W+1)'(push_n_i);
    rd_ptr_d  = rd_ptr_q + (PTR_W+1)'(pop_i);
    used_d    = used_q + (PTR_W+1)'(push_n_i) - (PTR_W+1)'(pop_i);
    empty_c   = (wr_ptr_q == rd_ptr_q);
    head_c    = mem_q[rd_ptr_q[PTR_W-1:0]];
    freeSlots = (PTR_W+1)'(DEPTH) - used_q;
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      used_q   <= used_d;
    end
  end

  // Storage writes; slot 0 always precedes slot 1 in queue order
  always_ff @(posedge clk) begin
    if (push_n_i != 2'd0) mem_q[wr_idx0] <= push0_i;
    if (push_n_i == 2'd2) mem_q[wr_idx1] <= push1_i;
  end

  assign used_o = used_q;

endmodule

// File: rtl/irq_event_queue.sv
// Queues key and breakpoint events and presents them to the CPU one at a time.
module irq_event_queue
  import rcpu_irq_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  keyPressed,
  input  logic [KEY_CODE_W-1:0] keyCode,
  input  logic                  keyEn,
  input  logic                  bpHit,
  input  logic [IRQ_DATA_W-1:0] bpData,
  input  logic [IRQ_VEC_W-1:0]  intVec,
  input  logic                  turnOffIRQ,
  output logic                  irq,
  output logic [IRQ_DATA_W-1:0] intData,
  output logic [IRQ_VEC_W-1:0]  intAddr,
  output logic                  intSrc,
  output logic [PTR_W:0]        count,
  output logic                  overflow,
  input  logic                  clrOvf
);

  irq_state_e     state_q, state_d;
  logic           irq_q, irq_d;
  irq_entry_t     out_q, out_d;
  logic           ovf_q, ovf_d;
  logic           key_prev_q, bp_prev_q;
  logic           armed_q;

  logic           key_ev, bp_ev, key_ok, bp_ok, pop;
  logic [1:0]     push_n;
  logic [PTR_W:0] free_slots, free_eff, key_need, used;
  irq_entry_t     key_entry, bp_entry, push0, head;
  logic           fifo_empty;

  // Edge detection and write arbitration (breakpoint wins the last slot)
  always_comb begin
    // armed_q masks the first edge after reset so levels already high are not events
    key_ev    = armed_q & keyEn & keyPressed & ~key_prev_q;
    bp_ev     = armed_q & bpHit & ~bp_prev_q;
    pop       = (state_q == IDLE) & ~fifo_empty;
    free_eff  = free_slots + (PTR_W+1)'(pop);
    bp_ok     = bp_ev & (free_eff != '0);
    key_need  = bp_ok ? (PTR_W+1)'(2) : (PTR_W+1)'(1);
    key_ok    = key_ev & (free_eff >= key_need);
    push_n    = {1'b0, bp_ok} + {1'b0, key_ok};
    key_entry = mk_key_entry(keyCode, intVec);
    bp_entry  = '{src: SRC_BP, data: bpData, vec: intVec};
    push0     = bp_ok ? bp_entry : key_entry;
    ovf_d     = ovf_q;
    if (clrOvf) ovf_d = 1'b0;
    if ((bp_ev & ~bp_ok) | (key_ev & ~key_ok)) ovf_d = 1'b1;
  end

  // Presenter next-state and output logic
  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          out_d   = head;
          irq_d   = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (turnOffIRQ) begin
          irq_d   = 1'b0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (!turnOffIRQ) state_d = IDLE;
      end
      default: begin
        irq_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, presented-event, flag and edge-history registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      irq_q      <= 1'b0;
      out_q      <= '0;
      ovf_q      <= 1'b0;
      key_prev_q <= 1'b0;
      bp_prev_q  <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_q      <= irq_d;
      out_q      <= out_d;
      ovf_q      <= ovf_d;
      key_prev_q <= keyPressed;
      bp_prev_q  <= bpHit;
      armed_q    <= 1'b1;
    end
  end

  irq_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_n_i  (push_n),
    .push0_i   (push0),
    .push1_i   (key_entry),
    .pop_i     (pop),
    .head_c    (head),
    .empty_c   (fifo_empty),
    .used_o    (used),
    .freeSlots (free_slots)
  );

  assign irq      = irq_q;
  assign intData  = out_q.data;
  assign intAddr  = out_q.vec;
  assign intSrc   = out_q.src;
  assign count    = used;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_irq_event_queue.sv
// Scoreboard bench for irq_event_queue: directed scenarios plus random traffic.
module tb_irq_event_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             keyPressed = 1'b0;
  logic [8:0]       keyCode = '0;
  logic             keyEn = 1'b1;
  logic             bpHit = 1'b0;
  logic [15:0]      bpData = '0;
  logic [31:0]      intVec = '0;
  logic             turnOffIRQ = 1'b0;
  logic             clrOvf = 1'b0;
  logic             irq;
  logic [15:0]      intData;
  logic [31:0]      intAddr;
  logic             intSrc;
  logic [PTR_W:0]   count;
  logic             overflow;

  typedef struct {
    logic        src;
    logic [15:0] data;
    logic [31:0] vec;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  pres_n = 0;      // 1 while an event is on the CPU lines and not yet acked
  logic exp_ovf = 1'b0;

  irq_event_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .keyPressed(keyPressed), .keyCode(keyCode), .keyEn(keyEn),
    .bpHit(bpHit), .bpData(bpData), .intVec(intVec), .turnOffIRQ(turnOffIRQ),
    .irq(irq), .intData(intData), .intAddr(intAddr), .intSrc(intSrc),
    .count(count), .overflow(overflow), .clrOvf(clrOvf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the DUT can hold DEPTH queued events plus one presented; beyond that it drops
  task automatic add_ev(input logic src, input logic [15:0] data);
    ev_t e;
    e.src  = src;
    e.data = data;
    e.vec  = intVec;
    if (exp_q.size() + pres_n < DEPTH + 1) exp_q.push_back(e);
    else exp_ovf = 1'b1;
  endtask

  task automatic ack_pulse();
    turnOffIRQ = 1'b1;
    pres_n     = 0;
    tick();
    turnOffIRQ = 1'b0;
  endtask

  task automatic wait_irq(input string name);
    for (int i = 0; i < 50; i++) begin
      if (irq === 1'b1) break;
      tick();
    end
    check(name, 64'(irq), 64'(1));
  endtask

  task automatic key_edge(input logic [8:0] code, input logic [31:0] vec);
    keyCode    = code;
    intVec     = vec;
    keyPressed = 1'b1;
    add_ev(1'b0, {7'b0, code});
    tick();
    keyPressed = 1'b0;
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_irq"},      64'(irq),      64'(0));
    check({tag, "_intData"},  64'(intData),  64'(0));
    check({tag, "_intAddr"},  64'(intAddr),  64'(0));
    check({tag, "_intSrc"},   64'(intSrc),   64'(0));
    check({tag, "_count"},    64'(count),    64'(0));
    check({tag, "_overflow"}, 64'(overflow), 64'(0));
  endtask

  // Monitor: pop the scoreboard on each presented event, check hold and low gap
  logic        irq_s   = 1'b0;
  int          low_cnt = 99;
  logic [48:0] cap     = '0;
  always @(negedge clk) begin
    if (!rst) begin
      irq_s   = 1'b0;
      low_cnt = 99;
    end else begin
      if (irq === 1'b1 && !irq_s) begin
        ev_t e;
        check("irq_low_gap", 64'(low_cnt >= 2), 64'(1));
        check("event_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("ev_intData", 64'(intData), 64'(e.data));
          check("ev_intAddr", 64'(intAddr), 64'(e.vec));
          check("ev_intSrc",  64'(intSrc),  64'(e.src));
        end
        cap    = {intSrc, intData, intAddr};
        pres_n = 1;
      end else if (irq === 1'b1) begin
        check("ev_hold_stable", 64'({intSrc, intData, intAddr}), 64'(cap));
      end
      if (irq === 1'b1) low_cnt = 0;
      else if (low_cnt < 99) low_cnt++;
      irq_s = (irq === 1'b1);
    end
  end

  int ack_cnt = 0;

  initial begin
    // Reset state
    #2 rst = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) tick();

    // Single key: 2-edge latency, 1-cycle ack
    keyCode = 9'h1C; intVec = 32'h0000_0100; keyPressed = 1'b1;
    add_ev(1'b0, 16'h001C);
    tick();
    check("single_e0_irq",   64'(irq),   64'(0));
    check("single_e0_count", 64'(count), 64'(1));
    keyPressed = 1'b0;
    tick();
    check("single_e1_irq",   64'(irq),   64'(1));
    check("single_e1_count", 64'(count), 64'(0));
    ack_pulse();
    check("single_ack_irq", 64'(irq), 64'(0));

    // Simultaneous breakpoint and key: breakpoint first
    repeat (3) tick();
    intVec = 32'h0000_0200; bpData = 16'hBEEF; bpHit = 1'b1; keyCode = 9'h05; keyPressed = 1'b1;
    add_ev(1'b1, 16'hBEEF);
    add_ev(1'b0, 16'h0005);
    tick();
    bpHit = 1'b0; keyPressed = 1'b0;
    wait_irq("sim_first");
    ack_pulse();
    check("sim_count", 64'(count), 64'(exp_q.size()));
    wait_irq("sim_second");
    ack_pulse();

    // Overflow: 10 key edges with no ack
    repeat (3) tick();
    for (int i = 0; i < 10; i++) key_edge(9'(9'h30 + i), 32'h1000 + 32'(i));
    repeat (4) tick();
    check("ovf_count", 64'(count),    64'(exp_q.size()));
    check("ovf_flag",  64'(overflow), 64'(exp_ovf));
    for (int i = 0; i < 9; i++) begin
      wait_irq("ovf_drain");
      ack_pulse();
    end
    repeat (3) tick();
    check("ovf_sticky", 64'(overflow), 64'(exp_ovf));
    clrOvf = 1'b1;
    tick();
    clrOvf  = 1'b0;
    exp_ovf = 1'b0;
    check("ovf_cleared", 64'(overflow), 64'(exp_ovf));

    // Level ack retires exactly one event
    for (int i = 0; i < 4; i++) key_edge(9'(9'h60 + i), 32'h2000 + 32'(i));
    repeat (4) tick();
    check("lvl_count_before", 64'(count), 64'(exp_q.size()));
    turnOffIRQ = 1'b1;
    pres_n     = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("lvl_irq_low",   64'(irq),   64'(0));
      check("lvl_count_hold", 64'(count), 64'(exp_q.size()));
    end
    turnOffIRQ = 1'b0;
    wait_irq("lvl_next");
    tick();
    check("lvl_count_after", 64'(count), 64'(exp_q.size()));
    ack_pulse();
    for (int i = 0; i < 2; i++) begin
      wait_irq("lvl_drain");
      ack_pulse();
    end

    // Gated key edge is discarded silently
    repeat (3) tick();
    keyEn = 1'b0; keyCode = 9'h77; keyPressed = 1'b1;
    tick();
    keyPressed = 1'b0;
    repeat (4) tick();
    keyEn = 1'b1;
    check("gate_irq",      64'(irq),      64'(0));
    check("gate_count",    64'(count),    64'(0));
    check("gate_overflow", 64'(overflow), 64'(0));

    // Asynchronous reset mid-operation, breakpoint level held through release
    for (int i = 0; i < 4; i++) key_edge(9'(9'h90 + i), 32'h3000 + 32'(i));
    wait_irq("rst_pre_irq");
    bpData = 16'h1234; bpHit = 1'b1;
    #1 rst = 1'b0;
    #1 check_reset_outputs("midrst");
    exp_q.delete();
    pres_n = 0;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) tick();
    check("bp_held_irq",   64'(irq),   64'(0));
    check("bp_held_count", 64'(count), 64'(0));
    bpHit = 1'b0;
    tick();
    intVec = 32'h4444_0000; bpHit = 1'b1;
    add_ev(1'b1, 16'h1234);
    tick();
    bpHit = 1'b0;
    wait_irq("bp_rerise");
    ack_pulse();

    // Random traffic, kept within capacity so nothing may be dropped
    for (int c = 0; c < 3000; c++) begin
      intVec = $urandom;
      keyEn  = ($urandom_range(0, 4) != 0);
      if (bpHit) bpHit = 1'b0;
      else if ($urandom_range(0, 3) == 0 && exp_q.size() + 3 <= DEPTH) begin
        bpData = 16'($urandom);
        bpHit  = 1'b1;
        add_ev(1'b1, bpData);
      end
      if (keyPressed) keyPressed = 1'b0;
      else if ($urandom_range(0, 2) == 0 && exp_q.size() + 3 <= DEPTH) begin
        keyCode    = 9'($urandom);
        keyPressed = 1'b1;
        if (keyEn) add_ev(1'b0, {7'b0, keyCode});
      end
      if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) turnOffIRQ = 1'b0;
      end else if (irq === 1'b1 && $urandom_range(0, 2) == 0) begin
        turnOffIRQ = 1'b1;
        pres_n     = 0;
        ack_cnt    = $urandom_range(1, 4);
      end
      tick();
    end
    turnOffIRQ = 1'b0; bpHit = 1'b0; keyPressed = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (irq === 1'b1) ack_pulse();
      else tick();
    end
    check("rand_drained",  64'(exp_q.size()), 64'(0));
    check("rand_count",    64'(count),        64'(0));
    check("rand_overflow", 64'(overflow),     64'(exp_ovf));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_event_queue.md
# irq_event_queue

Interrupt-event queue between the event sources (PS/2 key-press detector, RAM breakpoint flag) and the `rcpu` interrupt inputs. It replaces the single-register irq/intData/intAddr latch: edge-detects both sources, queues each event with its payload and vector in a small FIFO, and presents events to the CPU one at a time. The CPU acknowledges each event with `turnOffIRQ`. Events arriving while one is pending are therefore kept in order instead of being overwritten.

## Interface
Parameters:
- `DEPTH`, 8, FIFO entries; power of two, range 2..64.
- `PTR_W`, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- `clk`  in  1  single clock (the `fastClk` domain); all logic on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `keyPressed`  in  1  level from the keyboard reader; each rising edge is one key event.
- `keyCode`  in  9  scancode, valid when `keyPressed` rises.
- `keyEn`  in  1  gates key events (`switch[0]`); when low, key edges are discarded without an overflow.
- `bpHit`  in  1  breakpoint level, already synchronised to `clk`; each rising edge is one breakpoint event.
- `bpData`  in  16  breakpoint payload.
- `intVec`  in  32  handler address, sampled at enqueue.
- `turnOffIRQ`  in  1  CPU acknowledge; 1-cycle pulse or longer level.
- `irq`  out  1  event presented to the CPU.
- `intData`  out  16  payload of the presented event; a key event is {7'b0, keyCode}.
- `intAddr`  out  32  vector of the presented event.
- `intSrc`  out  1  source of the presented event: 0 = key, 1 = breakpoint.
- `count`  out  PTR_W+1  queued entries, excluding the one being presented.
- `overflow`  out  1  sticky; set when an event is dropped.
- `clrOvf`  in  1  clears `overflow`.

## Operation
- Edge detect: `keyPrev`/`bpPrev` registers. An event fires when the input is high and its prev register is low. A key event also requires `keyEn`.
- Entry layout: {src, data[15:0], vec[31:0]}, 49 bits.
- Enqueue on simultaneous events: the breakpoint is written first, then the key, so at most 2 writes per cycle. With only 1 free slot, the breakpoint is kept and the key is dropped.
- Full FIFO: an incoming event is dropped and `overflow` is set. If a pop happens in the same cycle, the freed slot counts as free.
- Presenter FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into the `intData`/`intAddr`/`intSrc` registers, set `irq`, and go to PRESENT.
  - PRESENT: hold the outputs stable. When `turnOffIRQ` is high, clear `irq` and go to GAP.
  - GAP: wait for `turnOffIRQ` low, then go to IDLE. A level-held ack therefore retires exactly one event.
- `turnOffIRQ` is ignored in IDLE.
- Output registers keep their last value after ack; only `irq` drops.
- `overflow`: set has priority over `clrOvf` in the same cycle.
- Reset values: `irq`=0, `intData`=0, `intAddr`=0, `intSrc`=0, `count`=0, `overflow`=0, FSM=IDLE, pointers=0, prev registers=0.
- Reset mid-operation discards all queued and presented events. An input already high at reset release is not counted as an event until it falls and rises again.

## Timing
- Input rises, sampled at edge E0: entry is written at E0, popped at E1, and `irq` is high after E1. Latency is 2 edges.
- Ack sampled high at edge A0: `irq` is low after A0. If `turnOffIRQ` is low at A1, the FSM reaches IDLE at A1 and can re-present at A2. This guarantees a minimum low time of 2 cycles between events.
- `intData`/`intAddr`/`intSrc` change only on the IDLE→PRESENT transition. They are valid the whole time `irq` is high.
- `count` is registered and reflects the previous edge's pushes and pops.
- Maximum sustained rate: 1 event per 3 cycles drained. Bursts up to DEPTH+1 are lossless, counting the presented slot.

## Structure
- Package `rcpu_irq_pkg`:
  - `SRC_KEY`=1'b0, `SRC_BP`=1'b1.
  - `IRQ_DATA_W`=16, `IRQ_VEC_W`=32, `IRQ_ENTRY_W`=49.
  - FSM state typedef {IDLE, PRESENT, GAP}.
- Sub-module `irq_sync_fifo`: DEPTH×49 storage with a 2-write/1-read port. It outputs `freeSlots`. Pointers use an extra wrap bit for full/empty.
- Top level: edge detectors, write arbitration, presenter FSM, overflow flag.

## Test plan
- Single key: `keyEn`=1, keyCode=9'h1C, intVec=32'h0000_0100, `keyPressed` rises → `irq` high 2 edges later, `intData`=16'h001C, `intAddr`=32'h100, `intSrc`=0. A 1-cycle ack drops `irq`.
- Simultaneous: bpData=16'hBEEF and keyCode=9'h05 rise together → first presented intData=16'hBEEF, intSrc=1. After ack and ≥2 cycles, intData=16'h0005, intSrc=0. `irq` is low for at least 2 cycles between them.
- Overflow: DEPTH=8, no ack, 10 key edges → 1 presented plus 8 queued (`count`=8), the 10th is dropped, `overflow`=1. Drain with 9 acks → payloads in order. `clrOvf` → `overflow`=0.
- Level ack: `turnOffIRQ` held high for 5 cycles with 3 queued events → exactly 1 event retired, and `count` is unchanged by the held level.
- Gating/reset: `keyEn`=0 plus a key edge → nothing queued, `overflow`=0. Assert `rst` low while `irq`=1 with 3 queued → all outputs 0 immediately (asynchronous). `bpHit` held high through reset release → no event until it re-rises.
